sparse_glb_egress: RTL and testbench

- Output stage of a sparse primitive tile that feeds the GLB write-back sink.
- Buffers 17-bit stream words (bit 16 = control flag) from the producing primitive in a small FIFO.
- Drives them to the GLB over ready/valid.
- Counts transmitted DONE tokens; after TX_NUM of them, stops streaming and raises done.

---
 rtl/sparse_stream_pkg.sv | 25 ++
 rtl/sparse_egress_fifo.sv | 72 +++++++
 rtl/sparse_glb_egress.sv | 134 +++++++++++++
 tb/tb_sparse_glb_egress.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_stream_pkg.sv
// Shared types for the sparse stream tiles: word layout, control tokens, egress FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sparse_stream_pkg;

  localparam int DATA_W   = 17;
  localparam int CTRL_BIT = 16;

  typedef logic [DATA_W-1:0] stream_word_t;

  localparam stream_word_t DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FIN,
    DONE
  } egress_state_e;

  // STOP tokens carry the control flag with a zero level field; they pass through untouched.
  function automatic logic is_stop(input stream_word_t word);
    return word[CTRL_BIT] && (word[15:8] == 8'h00);
  endfunction

endpackage

// File: rtl/sparse_egress_fifo.sv
// First-word-fall-through FIFO for the egress stream; head entry drives dout directly.
// Latency: a word pushed in cycle N is visible at dout/!empty in cycle N+1.
// Backpressure: push ignored when full, pop ignored when empty; flush empties synchronously.
module sparse_egress_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  // Extended pointers: the extra MSB separates full from empty without a counter.
  assign fill    = wr_ptr_q - rd_ptr_q;
  assign full    = (fill == DEPTH_V);
  assign empty   = (fill == '0);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage and pointers; flush drops everything buffered.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sparse_glb_egress.sv
// GLB egress stage: buffers sparse stream words, streams them out, stops after TX_NUM DONE tokens.
// Latency: one cycle from in_valid&&in_ready to out_valid (FWFT); done rises two cycles after the last DONE transfer.
// Backpressure: out_data held while out_valid&&!out_ready; in_ready drops when full or outside STREAM. Optional SPARSE_EGRESS_STATS_EN adds word_cnt/stop_cnt.
module sparse_glb_egress #(
  parameter int DEPTH  = 4,
  parameter int TX_NUM = 1,
  parameter int DATA_W = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fill
`ifdef SPARSE_EGRESS_STATS_EN
  ,
  output logic [15:0]              word_cnt,
  output logic [15:0]              stop_cnt
`endif
);

  import sparse_stream_pkg::*;

  localparam logic [7:0] TX_NUM_V = 8'(TX_NUM);

  egress_state_e state_q, state_d;
  logic [7:0]    done_cnt_q, done_cnt_d;
  logic          done_q, done_d;
  logic          fifo_full, fifo_empty;
  logic          push, pop, done_xfer;

  // Both handshakes are gated by STREAM so FIN/DONE freeze the FIFO contents.
  assign in_ready  = (state_q == STREAM) && !fifo_full;
  assign out_valid = (state_q == STREAM) && !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign done_xfer = pop && (out_data == DONE_TOKEN);
  assign done      = done_q;

  sparse_egress_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  // FSM and DONE-token counter; only transmitted DONE tokens count, never buffered ones.
  always_comb begin
    state_d    = state_q;
    done_cnt_d = done_cnt_q;
    if (flush) begin
      state_d    = IDLE;
      done_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE:   state_d = STREAM;
        STREAM: begin
          if (done_xfer && (done_cnt_q < TX_NUM_V)) begin
            done_cnt_d = done_cnt_q + 8'd1;
            if (done_cnt_d == TX_NUM_V) begin
              state_d = FIN;
            end
          end
        end
        FIN:    state_d = DONE;
        DONE:   state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == DONE);
  end

  // State, counter and registered done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      done_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_cnt_q <= done_cnt_d;
      done_q     <= done_d;
    end
  end

`ifdef SPARSE_EGRESS_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] stop_cnt_q, stop_cnt_d;

  assign word_cnt = word_cnt_q;
  assign stop_cnt = stop_cnt_q;

  // Transfer statistics; word_cnt wraps naturally at 2^16.
  always_comb begin
    word_cnt_d = word_cnt_q;
    stop_cnt_d = stop_cnt_q;
    if (flush) begin
      word_cnt_d = '0;
      stop_cnt_d = '0;
    end else if (pop) begin
      word_cnt_d = word_cnt_q + 16'd1;
      if (is_stop(out_data)) begin
        stop_cnt_d = stop_cnt_q + 16'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= '0;
      stop_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_sparse_glb_egress.sv
// Bench for sparse_glb_egress: directed steps plus a queue scoreboard on the output stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_sparse_glb_egress;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [16:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        done;
  logic [2:0]  fill;

  logic        flush2 = 1'b0;
  logic [16:0] in_data2 = '0;
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [16:0] out_data2;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic        done2;
  logic [2:0]  fill2;

`ifdef SPARSE_EGRESS_STATS_EN
  logic [15:0] word_cnt, stop_cnt, word_cnt2, stop_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  logic [16:0] q1[$];
  logic [16:0] q2[$];

  always #5 clk = ~clk;

  sparse_glb_egress #(.DEPTH(4), .TX_NUM(1), .DATA_W(17)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .fill(fill)
`ifdef SPARSE_EGRESS_STATS_EN
    , .word_cnt(word_cnt), .stop_cnt(stop_cnt)
`endif
  );

  sparse_glb_egress #(.DEPTH(4), .TX_NUM(2), .DATA_W(17)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .done(done2), .fill(fill2)
`ifdef SPARSE_EGRESS_STATS_EN
    , .word_cnt(word_cnt2), .stop_cnt(stop_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
  endtask

  // Scoreboard for dut: expected words queued on input acceptance, checked at the head while valid.
  always @(negedge clk) begin
    if (rst || flush) begin
      q1.delete();
    end else begin
      check("fill_bound", 32'(fill <= 3'd4), 32'd1);
      if (out_valid) begin
        check("sb_nonempty", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          check("out_data", 32'(out_data), 32'(q1[0]));
          if (out_ready) void'(q1.pop_front());
        end
      end
      if (in_valid && in_ready) q1.push_back(in_data);
    end
  end

  // Scoreboard for dut2 (TX_NUM=2).
  always @(negedge clk) begin
    if (rst || flush2) begin
      q2.delete();
    end else begin
      if (out_valid2) begin
        check("sb2_nonempty", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) begin
          check("out_data2", 32'(out_data2), 32'(q2[0]));
          if (out_ready2) void'(q2.pop_front());
        end
      end
      if (in_valid2 && in_ready2) q2.push_back(in_data2);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] basic [4];
    logic [16:0] bp [4];
    logic [16:0] tx2 [4];
    logic [16:0] rw;
    int idx;
    int cyc;

    basic = '{17'h00005, 17'h00007, 17'h10000, 17'h10100};
    bp    = '{17'h00011, 17'h10000, 17'h00013, 17'h00014};
    tx2   = '{17'h00001, 17'h10100, 17'h00002, 17'h10100};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    #2;
    rst = 1'b0;
    step();

    // Flush state
    flush = 1'b1;
    step();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_fill", 32'(fill), 32'd0);
    flush = 1'b0;
    step();
    check("stream_in_ready", 32'(in_ready), 32'd1);

    // Basic stream: each word visible the cycle after its push
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = basic[i];
      step();
      check("basic_valid", 32'(out_valid), 32'd1);
      check("basic_data", 32'(out_data), 32'(basic[i]));
    end
    in_valid = 1'b0;
    step();
    check("basic_fin_done", 32'(done), 32'd0);
    check("basic_fin_valid", 32'(out_valid), 32'd0);
    step();
    check("basic_done", 32'(done), 32'd1);
    check("basic_done_in_ready", 32'(in_ready), 32'd0);

    // Backpressure: fill to DEPTH, 5th push refused, head stable
    do_flush();
    check("bp_done_cleared", 32'(done), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = bp[i];
      step();
    end
    in_data = 17'h0000F;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_full_fill", 32'(fill), 32'd4);
    check("bp_head", 32'(out_data), 32'(bp[0]));
    step();
    check("bp_fill_held", 32'(fill), 32'd4);
    check("bp_head_held", 32'(out_data), 32'(bp[0]));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("bp_fill_drained", 32'(fill), 32'd0);
    check("bp_sb_drained", 32'(q1.size()), 32'd0);

    // Random ready/valid, no DONE tokens
    idx = 0;
    cyc = 0;
    rw  = 17'($urandom_range(0, 32'h1FFFF));
    if (rw == 17'h10100) rw = 17'h100FF;
    while (idx < 500 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 99) >= 30);
      in_data   = rw;
      out_ready = ($urandom_range(0, 99) >= 30);
      @(negedge clk);
      if (in_valid && in_ready) begin
        idx++;
        rw = 17'($urandom_range(0, 32'h1FFFF));
        if (rw == 17'h10100) rw = 17'h100FF;
      end
      step();
      cyc++;
    end
    check("rand_words_sent", 32'(idx), 32'd500);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q1.size() != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    check("rand_drained", 32'(q1.size()), 32'd0);
    check("rand_done", 32'(done), 32'd0);

    // Mid-stream flush with 3 words buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 17'h00030 + 17'(i);
      step();
    end
    in_valid = 1'b0;
    check("mf_fill_pre", 32'(fill), 32'd3);
    flush = 1'b1;
    step();
    check("mf_out_valid", 32'(out_valid), 32'd0);
    check("mf_fill", 32'(fill), 32'd0);
    check("mf_done", 32'(done), 32'd0);
    flush = 1'b0;
    step();
    check("mf_restream", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 17'h00021;
    step();
    in_data   = 17'h10100;
    step();
    in_valid  = 1'b0;
    step();
    step();
    check("mf_new_done", 32'(done), 32'd1);

    // Async reset while in DONE
    #2;
    rst = 1'b1;
    #1;
    check("arst_done", 32'(done), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    step();

    // TX_NUM=2: done only after the second transmitted DONE token
    out_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      in_data2  = tx2[i];
      step();
      check("tx2_done_early", 32'(done2), 32'd0);
    end
    in_valid2 = 1'b0;
    step();
    check("tx2_fin", 32'(done2), 32'd0);
    step();
    check("tx2_done", 32'(done2), 32'd1);
    in_valid2 = 1'b1;
    in_data2  = 17'h00003;
    for (int i = 0; i < 3; i++) begin
      step();
      check("tx2_post_valid", 32'(out_valid2), 32'd0);
      check("tx2_post_in_ready", 32'(in_ready2), 32'd0);
    end
    in_valid2 = 1'b0;

`ifdef SPARSE_EGRESS_STATS_EN
    // Statistics: two STOP tokens and one DONE token
    do_flush();
    check("stats_word_clr", 32'(word_cnt), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 17'h10000;
    step();
    step();
    in_data   = 17'h10100;
    step();
    in_valid  = 1'b0;
    step();
    step();
    check("stats_done", 32'(done), 32'd1);
    check("stats_word_cnt", 32'(word_cnt), 32'd3);
    check("stats_stop_cnt", 32'(stop_cnt), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
